// File: rtl/uart_rx_if.sv
// uart_rx_if: word handshake between the UART receiver (master) and the
// host-side register/FIFO logic (slave). Carries the received word, its
// valid/ready handshake and the one-clk error pulses.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output overrun_err,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun_err,
        output data_ready
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver. Start bit, LSB-first data,
// STOP_BITS stop bits. Received words are presented on rx_if with a
// valid/ready handshake; framing and overrun errors pulse for one clk.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority
// of the samples at tick_cnt 6/7/8, with the decision made at tick 8.
// Without it a single sample at tick 7 decides.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       baud_tick,
    input  logic       rx,
    uart_rx_if.master  rx_if,
    output logic       busy,
    output logic [2:0] dbg_rx_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DECIDE_TICK = 4'd8;
`else
    localparam logic [3:0] DECIDE_TICK = 4'd7;
`endif

    state_t               state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 rx_meta_q, rx_s_q, rx_prev_q;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]           samp_q, samp_d;
`endif

    logic handshake, fall, at_decide, at_wrap, bit_val;

    assign handshake = valid_q & rx_if.data_ready;
    assign fall      = rx_prev_q & ~rx_s_q;
    assign at_decide = baud_tick && (tick_q == DECIDE_TICK);
    assign at_wrap   = baud_tick && (tick_q == 4'd15);
`ifdef UART_RX_MAJORITY_EN
    assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
`else
    assign bit_val   = rx_s_q;
`endif

    // Next-state, counters, datapath and output pulses.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        stop_err_d = stop_err_q;
        data_d     = data_q;
        valid_d    = valid_q & ~handshake;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        samp_d     = samp_q;
        if (baud_tick && tick_q == 4'd6) samp_d[0] = rx_s_q;
        if (baud_tick && tick_q == 4'd7) samp_d[1] = rx_s_q;
`endif
        // Bit timing only runs while a frame is in progress.
        if ((state_q == START || state_q == DATA || state_q == STOP) && baud_tick)
            tick_d = tick_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (enable && fall) begin
                    state_d    = START;
                    tick_d     = 4'd0;
                    bit_d      = 4'd0;
                    stop_err_d = 1'b0;
                end
            end
            START: begin
                if (at_decide && bit_val) begin
                    state_d = IDLE;          // line back high: glitch, not a start bit
                    tick_d  = 4'd0;
                end else if (at_wrap) begin
                    state_d = DATA;
                    bit_d   = 4'd0;
                end
            end
            DATA: begin
                if (at_decide) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                if (at_wrap) begin
                    if (bit_q == LAST_DATA) begin
                        state_d = STOP;
                        bit_d   = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (at_decide) begin
                    if (!bit_val) stop_err_d = 1'b1;
                    // Leave at the last stop sample so a following start edge is not missed.
                    if (bit_q == LAST_STOP) state_d = DONE;
                end else if (at_wrap) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            DONE: begin
                data_d  = shift_q;
                ferr_d  = stop_err_q;
                ovr_d   = valid_q & ~handshake;
                valid_d = 1'b1;
                state_d = IDLE;
                tick_d  = 4'd0;
            end
            default: state_d = IDLE;
        endcase

        // Disable aborts the frame silently; the last delivered word stays put.
        if (!enable) begin
            state_d = IDLE;
            tick_d  = 4'd0;
            bit_d   = 4'd0;
            data_d  = data_q;
            valid_d = valid_q & ~handshake;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State, synchroniser and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_q     <= 4'd0;
            bit_q      <= 4'd0;
            shift_q    <= '0;
            stop_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            samp_q     <= 2'b11;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
`ifdef UART_RX_MAJORITY_EN
            samp_q     <= samp_d;
`endif
        end
    end

    assign rx_if.data_out    = data_q;
    assign rx_if.data_valid  = valid_q;
    assign rx_if.frame_err   = ferr_q;
    assign rx_if.overrun_err = ovr_q;
    assign busy              = (state_q != IDLE);
    assign dbg_rx_state      = state_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver: the downstream stage of uart_tx, consuming the same serial line format (start bit, LSB-first data, stop bits).
- Oversamples the line at 16x using a baud_tick from the shared baud generator.
- Deserialises each frame into a parallel word and presents it on a valid/ready handshake to the host-side register/FIFO logic.
- Flags framing and overrun errors.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bits checked per frame (1 or 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  receiver enable; low aborts any frame in progress.
- baud_tick  input  1  one-clk pulse at 16x the bit rate.
- rx  input  1  asynchronous serial input; idle high.
- data_out  output  DATA_BITS  last received word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts the word when data_valid & data_ready.
- busy  output  1  frame in progress (state != IDLE).
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun_err  output  1  one-clk pulse: frame completed while data_valid was still high.
- dbg_rx_state  output  3  current state encoding.

Behaviour:
- All state updates on posedge clk. Reset is synchronous: rst_n low at a clk edge forces reset values.
- Reset values: data_out=0, data_valid=0, busy=0, frame_err=0, overrun_err=0, dbg_rx_state=IDLE, internal sync flops=1.
- rx passes through a 2-flop synchroniser (rx_s). Falling-edge detect uses rx_s and its previous value.
- States and encodings: IDLE=0, START=1, DATA=2, STOP=3, DONE=4.
- Counters:
  - tick_cnt: 4 bits, advances only on baud_tick, wraps 15->0; each wrap is one bit period.
  - bit_cnt: counts data bits and stop bits.
- Sample point: tick_cnt==7 in the current bit period (single sample).
- IDLE:
  - Condition: enable=1 and rx_s falling edge.
  - Action: go to START with tick_cnt=0. No baud_tick is required for the detect.
- START:
  - At the sample point: rx_s=1 means a glitch, return to IDLE with no error flagged.
  - rx_s=0 continues. At the tick_cnt wrap, go to DATA with bit_cnt=0.
- DATA:
  - At each sample point, shift rx_s into the MSB of the shift register (LSB-first reception).
  - At the wrap after bit DATA_BITS-1, go to STOP.
- STOP:
  - At each stop-bit sample point, record a 0 in an internal error bit.
  - After the last stop bit's sample point, go to DONE immediately, without waiting for the end of that bit. This allows back-to-back frames.
  - For STOP_BITS=2, the first stop bit runs its full 16 ticks.
- DONE (exactly 1 clk):
  - data_out <= shift register.
  - frame_err pulses if any stop sample was 0.
  - overrun_err pulses if data_valid was 1 entering DONE and no handshake completes in that same cycle.
  - data_valid <= 1.
  - Next state: IDLE.
- The word is written to data_out even on frame error. Break condition (rx held low): data_out=0x00 and frame_err=1.
- Handshake:
  - data_valid clears the cycle after data_valid & data_ready.
  - Simultaneous DONE and handshake: the new word wins, data_valid stays 1, no overrun.
  - Overrun overwrites data_out.
- enable low (any state):
  - Next clk goes to IDLE, busy=0, and counters clear.
  - The aborted frame produces no data_valid or errors.
  - data_out and data_valid are retained.
  - Re-enable requires a fresh falling edge.
- baud_tick ignored in IDLE and DONE.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rx_s sampled at tick_cnt 6, 7 and 8. Decisions (start glitch check, data shift, stop check) happen at tick_cnt==8.
- Undefined: single sample at tick_cnt==7 as above.
- All other timing is identical; the STOP exit occurs at the decision tick.

Test Plan:
- Idle, enable=0, drive a 0x55 frame -> busy stays 0, data_valid stays 0, dbg_rx_state=0.
- enable=1, frames 0x55, 0xAA, 0x00, 0xFF at 16 ticks/bit, data_ready pulsed after each -> data_out matches each, data_valid set once per frame, frame_err=0, dbg_rx_state returns to 0.
- rx low for 4 ticks then high -> START then back to IDLE, no data_valid, no errors. Repeat with 10-tick low -> frame proceeds (data bits all 1, stop 1): data_out=0xFF.
- Frame 0x3C with stop bit driven 0 -> data_out=0x3C, frame_err pulses exactly 1 clk; continuous low break -> data_out=0x00, frame_err=1.
- data_ready=0, frames 0x12 then 0x34 back-to-back -> second DONE gives overrun_err 1-clk pulse, data_out=0x34, data_valid=1. Then data_ready=1 -> data_valid clears next clk.
- Drop enable=0 mid-DATA of 0xB2 -> within 1 clk busy=0, state=IDLE, no data_valid. Re-enable and send 0xC3 -> received correctly.
- With UART_RX_MAJORITY_EN: a 1-tick glitch inverting rx at tick 7 of every data bit of 0x5A -> data_out=0x5A. Without the macro, the same stimulus yields 0xA5.
